// File: rtl/tile_pattern_fetcher_if.sv
// tile_pattern_fetcher_if
//   Memory-side bus of the tile pattern fetcher: the tile-map read channel
//   (request/acknowledge handshake) and the synchronous pattern ROM port.
//
//   map_req    fetcher -> map   read request, held with map_addr until map_ack
//   map_addr   fetcher -> map   tile index row*MAP_COLS+col
//   map_ack    map -> fetcher   read done; map_rdata valid in the same cycle
//   map_rdata  map -> fetcher   tile-map entry
//   pat_addr   fetcher -> ROM   {code[7:0], py[3:0], px[3:0]}
//   pat_rdata  ROM -> fetcher   2-bit colour index, one Clk after pat_addr
//
//   master: the fetcher.  slave: the tile-map memory / pattern ROM.
interface tile_pattern_fetcher_if;
  logic        map_req;
  logic [10:0] map_addr;
  logic        map_ack;
  logic [7:0]  map_rdata;
  logic [15:0] pat_addr;
  logic [1:0]  pat_rdata;

  modport master (
    output map_req, map_addr, pat_addr,
    input  map_ack, map_rdata, pat_rdata
  );

  modport slave (
    input  map_req, map_addr, pat_addr,
    output map_ack, map_rdata, pat_rdata
  );
endinterface

// File: rtl/tile_pattern_fetcher.sv
// tile_pattern_fetcher
//   Per-pixel producer of the tile shape code and 2-bit colour index for the
//   colour mapper. One row of tile-map entries is prefetched per tile row
//   into a ping-pong line buffer during horizontal blanking; the pixel path
//   reads the front bank and looks the pixel up in a synchronous pattern ROM.
//
//   Ports
//     Clk, Reset_n      clock, asynchronous active-low reset
//     pixel_en          pixel strobe (at most one per 2 Clk)
//     DrawX, DrawY      current pixel coordinates, valid with pixel_en
//     bus               tile-map read channel and pattern ROM port (master)
//     export_pattern    shape code of the pixel two strobes back
//     extend_color      colour index of that pixel (0 when outside the frame)
//     DrawX_d, DrawY_d  coordinates aligned with export_pattern/extend_color
//     underrun          sticky: a row fetch was still running at its swap point
//
//   Build option
//     TILE_FLIP_EN  map entry bit 7 flips the tile horizontally, bit 6
//                   vertically, and bits 5:0 form the shape code. The full
//                   8-bit entry is buffered, so the flip bits travel with it.
module tile_pattern_fetcher #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned MAP_COLS = 40
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pixel_en,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  tile_pattern_fetcher_if.master      bus,
  output logic [7:0]                  export_pattern,
  output logic [1:0]                  extend_color,
  output logic [9:0]                  DrawX_d,
  output logic [9:0]                  DrawY_d,
  output logic                        underrun
);

  localparam int unsigned COL_W = $clog2(MAP_COLS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    READY
  } state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic              req_q;
  logic [10:0]       addr_q;
  logic [9:0]        target_line;
  logic              front_sel;

  // Line buffer banks; bank[front_sel] is displayed, the other is filled.
  logic [7:0]        bank0 [MAP_COLS];
  logic [7:0]        bank1 [MAP_COLS];

  logic [9:0]        next_line;
  logic              trigger;
  logic              swap_point;
  logic              swap_now;
  logic              fetch_wr;

  logic [5:0]        rd_tile;
  logic [5:0]        rd_idx;
  logic              rd_sel;
  logic [7:0]        rd_entry;
  logic [7:0]        rd_code;
  logic [3:0]        rd_px;
  logic [3:0]        rd_py;

  logic [7:0]        s1_code;
  logic [3:0]        s1_px;
  logic [3:0]        s1_py;
  logic [9:0]        s1_x;
  logic [9:0]        s1_y;
  logic              s1_active;

  assign bus.map_req  = req_q;
  assign bus.map_addr = addr_q;
  assign bus.pat_addr = {s1_code, s1_py, s1_px};

  // Fetch trigger: first blanking pixel of the line before a tile-row start.
  always_comb begin
    next_line  = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    trigger    = pixel_en && (DrawX == 10'(H_ACTIVE)) &&
                 (next_line < 10'(V_ACTIVE)) && (next_line[3:0] == 4'd0);
    swap_point = pixel_en && (DrawX == 10'd0) && (DrawY == target_line);
    swap_now   = (state == READY) && swap_point;
    fetch_wr   = (state == FETCH) && req_q && bus.map_ack && !swap_point;
  end

  // Row fetch FSM: IDLE -> FETCH on trigger, FETCH -> READY after the last
  // column, READY -> IDLE with a bank swap at the first pixel of the target
  // line. A fetch still running at that point is abandoned (underrun).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      col         <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      target_line <= '0;
      front_sel   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state       <= FETCH;
            col         <= '0;
            req_q       <= 1'b1;
            addr_q      <= 11'(next_line[8:4]) * 11'(MAP_COLS);
            target_line <= next_line;
          end
        end
        FETCH: begin
          if (swap_point) begin
            req_q    <= 1'b0;
            underrun <= 1'b1;
            state    <= IDLE;
          end else if (bus.map_ack) begin
            if (col == COL_W'(MAP_COLS - 1)) begin
              req_q <= 1'b0;
              state <= READY;
            end else begin
              col    <= col + COL_W'(1);
              addr_q <= addr_q + 11'd1;
            end
          end
        end
        READY: begin
          if (swap_point) begin
            front_sel <= ~front_sel;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer contents carry no reset; they are only meaningful after a fetch.
  always_ff @(posedge Clk) begin
    if (fetch_wr) begin
      if (front_sel) begin
        bank0[col] <= bus.map_rdata;
      end else begin
        bank1[col] <= bus.map_rdata;
      end
    end
  end

  // The swap and the first pixel of the new row share a strobe, so that
  // pixel reads the bank that becomes the front bank on this edge.
  always_comb begin
    rd_tile  = DrawX[9:4];
    rd_idx   = (rd_tile < 6'(MAP_COLS)) ? rd_tile : 6'd0;
    rd_sel   = front_sel ^ swap_now;
    rd_entry = rd_sel ? bank1[rd_idx] : bank0[rd_idx];
`ifdef TILE_FLIP_EN
    rd_code  = {2'b00, rd_entry[5:0]};
    rd_px    = rd_entry[7] ? ~DrawX[3:0] : DrawX[3:0];
    rd_py    = rd_entry[6] ? ~DrawY[3:0] : DrawY[3:0];
`else
    rd_code  = rd_entry;
    rd_px    = DrawX[3:0];
    rd_py    = DrawY[3:0];
`endif
  end

  // Two-stage pixel pipeline advanced by pixel_en; stage 2 samples the ROM
  // answer to the address stage 1 presented on the previous strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_code        <= '0;
      s1_px          <= '0;
      s1_py          <= '0;
      s1_x           <= '0;
      s1_y           <= '0;
      s1_active      <= 1'b0;
      export_pattern <= '0;
      extend_color   <= '0;
      DrawX_d        <= '0;
      DrawY_d        <= '0;
    end else if (pixel_en) begin
      s1_code        <= rd_code;
      s1_px          <= rd_px;
      s1_py          <= rd_py;
      s1_x           <= DrawX;
      s1_y           <= DrawY;
      s1_active      <= (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
      export_pattern <= s1_active ? s1_code : '0;
      extend_color   <= s1_active ? bus.pat_rdata : '0;
      DrawX_d        <= s1_x;
      DrawY_d        <= s1_y;
    end
  end

endmodule

// File: tb/tb_tile_pattern_fetcher.sv
module tb_tile_pattern_fetcher;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       pixel_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] export_pattern;
  logic [1:0] extend_color;
  logic [9:0] DrawX_d;
  logic [9:0] DrawY_d;
  logic       underrun;

  tile_pattern_fetcher_if bus ();

  tile_pattern_fetcher #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .V_TOTAL (525),
    .MAP_COLS(40)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .pixel_en      (pixel_en),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .bus           (bus),
    .export_pattern(export_pattern),
    .extend_color  (extend_color),
    .DrawX_d       (DrawX_d),
    .DrawY_d       (DrawY_d),
    .underrun      (underrun)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    int pat;
    int col;
    bit chk;
    int pa;
    bit pa_chk;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int map_mem [2048];
  int disp [40];
  bit disp_valid = 1'b0;
  bit pending    = 1'b0;
  int pend_line  = 0;
  int pend_row   = 0;
  bit pend_ok    = 1'b0;
  int stuck_row  = -1;
  bit und_exp    = 1'b0;
  int ack_delay  = 0;
  int ack_cnt    = 0;

  // Pattern ROM contents: colour = px[1:0] ^ py[1:0] ^ code[3:2]
  function automatic int rom(input int code, input int py, input int px);
    return (px & 3) ^ (py & 3) ^ ((code >> 2) & 3);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk)
    bus.pat_rdata <= 2'(rom(int'(bus.pat_addr[15:8]), int'(bus.pat_addr[7:4]),
                            int'(bus.pat_addr[3:0])));

  // Tile-map memory: acks after ack_delay wait cycles, never for stuck_row.
  initial begin
    int wait_cnt;
    bit prev_req;
    wait_cnt      = 0;
    prev_req      = 1'b0;
    bus.map_ack   = 1'b0;
    bus.map_rdata = '0;
    forever begin
      @(posedge Clk);
      #1;
      bus.map_ack   = 1'b0;
      bus.map_rdata = 8'($urandom);
      if (Reset_n && bus.map_req) begin
        if (!prev_req) begin
          ack_cnt  = 0;
          wait_cnt = 0;
        end
        check("req_expected", int'(pending), 1);
        check("map_addr", int'(bus.map_addr), pend_row * 40 + ack_cnt);
        if (pend_row != stuck_row) begin
          if (wait_cnt >= ack_delay) begin
            bus.map_ack   = 1'b1;
            bus.map_rdata = 8'(map_mem[bus.map_addr]);
            ack_cnt++;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
      prev_req = Reset_n && bus.map_req;
    end
  end

  // Output monitor: each strobe presents the pixel issued one strobe earlier.
  int strobes = 0;
  always @(posedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      strobes = 0;
      sbq.delete();
    end else if (pixel_en) begin
      #1;
      strobes++;
      if (sbq.size() > 0 && sbq[$].pa_chk)
        check("pat_addr", int'(bus.pat_addr), sbq[$].pa);
      if (strobes >= 2) begin
        if (sbq.size() < 2) begin
          check("sb_depth", sbq.size(), 2);
        end else begin
          e = sbq.pop_front();
          check("DrawX_d", int'(DrawX_d), e.x);
          check("DrawY_d", int'(DrawY_d), e.y);
          if (e.chk) begin
            check("export_pattern", int'(export_pattern), e.pat);
            check("extend_color", int'(extend_color), e.col);
          end
        end
      end
    end
  end

  // Issue one pixel (called at a falling edge); model updates first.
  task automatic pix(input int x, input int y);
    exp_t e;
    int ent, code, px, py, n;
    if (x == 0 && pending && y == pend_line) begin
      if (pend_ok) begin
        for (int c = 0; c < 40; c++) disp[c] = map_mem[pend_row * 40 + c];
        disp_valid = 1'b1;
      end else begin
        und_exp = 1'b1;
      end
      pending = 1'b0;
    end
    e.x = x; e.y = y; e.pat = 0; e.col = 0; e.chk = 1'b1; e.pa = 0; e.pa_chk = 1'b0;
    if (x < 640 && y < 480) begin
      if (disp_valid) begin
        ent = disp[x / 16];
        px  = x % 16;
        py  = y % 16;
`ifdef TILE_FLIP_EN
        code = ent & 63;
        if ((ent & 128) != 0) px = 15 - px;
        if ((ent & 64) != 0)  py = 15 - py;
`else
        code = ent;
`endif
        e.pat    = code;
        e.col    = rom(code, py, px);
        e.pa     = code * 256 + py * 16 + px;
        e.pa_chk = 1'b1;
      end else begin
        e.chk = 1'b0;
      end
    end
    sbq.push_back(e);
    if (x == 640 && !pending) begin
      n = (y == 524) ? 0 : y + 1;
      if (n < 480 && n % 16 == 0) begin
        pending   = 1'b1;
        pend_line = n;
        pend_row  = n / 16;
        pend_ok   = (pend_row != stuck_row);
      end
    end
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    pixel_en = 1'b1;
    @(negedge Clk);
    pixel_en = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge Clk);
  endtask

  task automatic run_line(input int y, input bit sweep);
    pix(0, y);
    check("underrun", int'(underrun), int'(und_exp));
    repeat (10) pix($urandom_range(1, 639), y);
    if (sweep) pix(37, y);
    pix($urandom_range(641, 799), y);
    pix(640, y);
    for (int x = 641; x <= 740; x++) pix(x, y);
    if (pending && pend_ok) check("ack_total", ack_cnt, 40);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_map_req"}, int'(bus.map_req), 0);
    check({tag, "_export_pattern"}, int'(export_pattern), 0);
    check({tag, "_extend_color"}, int'(extend_color), 0);
    check({tag, "_DrawX_d"}, int'(DrawX_d), 0);
    check({tag, "_DrawY_d"}, int'(DrawY_d), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
    check({tag, "_pat_addr"}, int'(bus.pat_addr), 0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    pixel_en = 1'b0;
    DrawX    = '0;
    DrawY    = '0;
    for (int i = 0; i < 2048; i++) map_mem[i] = i % 256;
`ifdef TILE_FLIP_EN
    map_mem[0] = 8'h85;
`endif
    repeat (3) @(negedge Clk);
    check_reset("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // Zero-wait map, frame start and the first tile row
    ack_delay = 0;
    stuck_row = -1;
    run_line(524, 1'b0);
    for (int y = 0; y <= 16; y++) run_line(y, y == 0);

    // Slow map: 3 wait cycles per request
    ack_delay = 3;
    run_line(31, 1'b0);
    run_line(32, 1'b0);
    run_line(524, 1'b0);
    run_line(0, 1'b1);

    // Random map contents; row 1 never acknowledged -> underrun at line 16
    for (int i = 0; i < 2048; i++) map_mem[i] = $urandom_range(0, 255);
    ack_delay = $urandom_range(0, 3);
    stuck_row = 1;
    run_line(15, 1'b0);
    run_line(16, 1'b0);
    stuck_row = -1;
    run_line(31, 1'b0);
    run_line(32, 1'b0);

    // Reset in the middle of a fetch, then a clean refetch
    ack_delay = 3;
    pix(0, 47);
    pix(640, 47);
    for (int i = 0; i < 2000 && ack_cnt < 20; i++) @(negedge Clk);
    check("mid_fetch_progress", ack_cnt, 20);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset("mid_fetch_reset");
    pending    = 1'b0;
    disp_valid = 1'b0;
    und_exp    = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_line(47, 1'b0);
    run_line(48, 1'b1);
    run_line(49, 1'b0);

    repeat (4) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/tile_pattern_fetcher.md
# tile_pattern_fetcher

Per-pixel producer of the shape code and 2-bit colour index consumed by the colour mapper. Takes the VGA controller's DrawX/DrawY stream, prefetches one row of tile-map entries per tile row into a ping-pong line buffer during horizontal blanking, and looks up the 2-bit pixel colour in a synchronous pattern ROM. Sits between the VGA controller, tile-map memory and pattern ROM on one side, and the colour mapper on the other.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, total lines per frame
- MAP_COLS, 40, tiles per row; tile size is fixed at 16x16
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  pixel strobe; at most one per 2 Clk cycles
- DrawX, DrawY  in  10  current pixel coordinates, valid when pixel_en
- map_req  out  1  tile-map read request
- map_addr  out  11  tile index, row*MAP_COLS+col (0..1199)
- map_ack  in  1  read done; map_rdata valid in the same cycle
- map_rdata  in  8  tile-map entry
- pat_addr  out  16  {code[7:0], py[3:0], px[3:0]}; synchronous ROM, 1-Clk latency
- pat_rdata  in  2  pixel colour index
- export_pattern  out  8  shape code for the delayed pixel
- extend_color  out  2  colour index for the delayed pixel
- DrawX_d, DrawY_d  out  10  coordinates aligned with outputs
- underrun  out  1  sticky: a row fetch missed its deadline

## Operation
- Line buffer: two banks of MAP_COLS 8-bit entries; front bank is read by the pixel path, back bank is written by the fetch FSM.
- Fetch trigger: on pixel_en with DrawX==H_ACTIVE, where the next line N=(DrawY==V_TOTAL-1)?0:DrawY+1 satisfies N<V_ACTIVE and N[3:0]==0, fetch tile row N>>4.
- FSM IDLE -> FETCH: col=0; map_req=1, map_addr=(N>>4)*MAP_COLS+col. Each cycle with map_req && map_ack: write map_rdata to back[col] and increment col. After col MAP_COLS-1 -> READY. At most one request is outstanding.
- READY -> IDLE: at the first pixel_en of line N with DrawX==0, swap the banks.
- Deadline: if the FSM is still in FETCH at that swap point, drop map_req, set underrun, go to IDLE, and do not swap. The previous row stays displayed.
- A trigger while not in IDLE is ignored.
- Pixel path, stage 1 (on pixel_en):
  - register code=front[DrawX>>4], px=DrawX[3:0], py=DrawY[3:0], and the coordinates plus an active flag (DrawX<H_ACTIVE && DrawY<V_ACTIVE);
  - pat_addr is driven from these registers.
- Pixel path, stage 2 (next pixel_en): register export_pattern=code and extend_color=pat_rdata, or 0/0 if inactive. DrawX_d/DrawY_d advance with them.
- Reset (asynchronous, any state including mid-fetch) forces all outputs to 0, map_req to 0, underrun to 0, FSM to IDLE and front bank select to 0. Buffer contents are undefined until the first fetch.

## Timing
- Output latency: 2 pixel_en strobes from DrawX/DrawY to export_pattern/extend_color/DrawX_d/DrawY_d.
- Between strobes, outputs are held.
- The pixel_en spacing of at least 2 Clk guarantees pat_rdata is stable at stage 2.
- map_addr and map_req are held stable until the ack cycle. The next request may issue in the cycle after an ack.
- Zero-wait memory completes a row in 40 Clk. The budget at 2 Clk/pixel is 160 blanking pixels = 320 Clk.
- Line 0 is fetched during blanking of line V_TOTAL-1.
- Counters: col wraps only via the FSM. The row index is 5 bits (0..29).

## Configuration
- TILE_FLIP_EN defined:
  - map_rdata[7] = horizontal flip, [6] = vertical flip;
  - code = {2'b00, map_rdata[5:0]};
  - px/py are inverted (15-x) when the corresponding flip bit is set;
  - flip bits are stored alongside each buffer entry.
- TILE_FLIP_EN undefined: code = map_rdata[7:0], no flip logic, no extra buffer bits.

## Test plan
- Zero-wait map with map[i]=i%256, ROM returns px[1:0], DrawX sweep of line 0 -> at DrawX_d=37, export_pattern=2, extend_color=1; at DrawX_d=700, both are 0.
- map_ack delayed 3 cycles per request -> 40 acks, map_addr 0..39 each held until its ack, row still ready before line 0, underrun stays 0.
- map_ack stuck low during the fetch for line 16 -> underrun=1 at line 16 DrawX=0, line 16 shows row-0 codes, and the fetch for line 32 proceeds normally.
- Reset_n pulsed low mid-fetch at col 20 -> map_req=0 and outputs 0 immediately, and the next trigger refetches from col 0.
- Lines 1..15 -> no map_req issued and the same codes are displayed as on line 0.
- With TILE_FLIP_EN: entry 0x85 at tile 0 -> export_pattern=5, pat_addr px=15 at DrawX=0.
